// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 integer register file.
// Holds the sizing parameters, the sequencer state type and the write-qualification helpers.
package msrv32_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] X0_ADDR = 5'd0;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  // A write-back is architecturally visible only when enabled and not aimed at x0.
  function automatic logic rf_wr_valid(input logic wr_en, input logic [ADDR_W-1:0] rd_addr);
    return wr_en && (rd_addr != X0_ADDR);
  endfunction

  function automatic logic rf_wr_hit(input logic              wr_en,
                                     input logic [ADDR_W-1:0] rd_addr,
                                     input logic [ADDR_W-1:0] rs_addr);
    return rf_wr_valid(wr_en, rd_addr) && (rd_addr == rs_addr);
  endfunction

endpackage

// File: rtl/msrv32_rf_read_port.sv
// One registered read port of the integer file.
// Selects write-first bypass data or array data, forces x0 and not-ready reads to zero.
module msrv32_rf_read_port
  import msrv32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]   mem_data,
  output logic [XLEN-1:0]   rs_data
);

  logic [XLEN-1:0] rs_next_s;
  logic [XLEN-1:0] rs_data_r;

  // Next read value: x0 masking wins over bypass so x0 stays zero even when targeted.
  always_comb begin
    rs_next_s = '0;
    if (!run) begin
      rs_next_s = '0;
    end else if (rs_addr == X0_ADDR) begin
      rs_next_s = '0;
    end else if (rf_wr_hit(wr_en, rd_addr, rs_addr)) begin
      rs_next_s = rd_data;
    end else begin
      rs_next_s = mem_data;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_data_r <= '0;
    end else begin
      rs_data_r <= rs_next_s;
    end
  end

  assign rs_data = rs_data_r;

endmodule

// File: rtl/msrv32_integer_file.sv
// Architectural integer register file x0..x31 with two registered read ports.
// After reset a sequencer zeroes every entry before the file reports ready.
module msrv32_integer_file
  import msrv32_pkg::*;
(
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic              wr_en_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic [XLEN-1:0]   rd_in,
  input  logic [ADDR_W-1:0] rs1_addr_in,
  input  logic [ADDR_W-1:0] rs2_addr_in,
  output logic [XLEN-1:0]   rs1_out,
  output logic [XLEN-1:0]   rs2_out,
  output logic              rf_ready_out,
  output logic              wr_drop_out
);

  rf_state_t         state_r;
  rf_state_t         state_next_s;
  logic [ADDR_W-1:0] clr_idx_r;
  logic [ADDR_W-1:0] clr_idx_next_s;
  logic [XLEN-1:0]   mem_r [NREGS];
  logic              ready_r;
  logic              drop_r;
  logic              run_s;
  logic              clr_last_s;
  logic              wr_go_s;

  assign run_s      = (state_r == RF_RUN);
  assign clr_last_s = (clr_idx_r == ADDR_W'(NREGS - 1));
  assign wr_go_s    = run_s && rf_wr_valid(wr_en_in, rd_addr_in);

  // Clear sequencer next-state: walk every index once, then stay in RUN.
  always_comb begin
    state_next_s   = state_r;
    clr_idx_next_s = clr_idx_r;
    case (state_r)
      RF_INIT: begin
        clr_idx_next_s = clr_idx_r + ADDR_W'(1);
        if (clr_last_s) begin
          state_next_s = RF_RUN;
        end else begin
          state_next_s = RF_INIT;
        end
      end
      RF_RUN: begin
        state_next_s   = RF_RUN;
        clr_idx_next_s = clr_idx_r;
      end
      default: begin
        state_next_s   = RF_INIT;
        clr_idx_next_s = '0;
      end
    endcase
  end

  // Sequencer state, ready flag and dropped-write pulse.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_r   <= RF_INIT;
      clr_idx_r <= '0;
      ready_r   <= 1'b0;
      drop_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      clr_idx_r <= clr_idx_next_s;
      ready_r   <= (state_next_s == RF_RUN);
      drop_r    <= wr_en_in && !run_s;
    end
  end

  // Storage: not reset directly, the INIT walk owns the write port until RUN.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      if (!run_s) begin
        mem_r[clr_idx_r] <= '0;
      end else if (wr_go_s) begin
        mem_r[rd_addr_in] <= rd_in;
      end
    end
  end

  msrv32_rf_read_port u_rs1_port (
    .clk      (ms_riscv32_mp_clk_in),
    .rst      (ms_riscv32_mp_rst_in),
    .run      (run_s),
    .wr_en    (wr_en_in),
    .rd_addr  (rd_addr_in),
    .rd_data  (rd_in),
    .rs_addr  (rs1_addr_in),
    .mem_data (mem_r[rs1_addr_in]),
    .rs_data  (rs1_out)
  );

  msrv32_rf_read_port u_rs2_port (
    .clk      (ms_riscv32_mp_clk_in),
    .rst      (ms_riscv32_mp_rst_in),
    .run      (run_s),
    .wr_en    (wr_en_in),
    .rd_addr  (rd_addr_in),
    .rd_data  (rd_in),
    .rs_addr  (rs2_addr_in),
    .mem_data (mem_r[rs2_addr_in]),
    .rs_data  (rs2_out)
  );

  assign rf_ready_out = ready_r;
  assign wr_drop_out  = drop_r;

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed self-checking bench for msrv32_integer_file.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_msrv32_integer_file;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rf_ready;
  logic        wr_drop;

  int n_checks;
  int n_fail;

  msrv32_integer_file dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .wr_en_in             (wr_en),
    .rd_addr_in           (rd_addr),
    .rd_in                (rd_data),
    .rs1_addr_in          (rs1_addr),
    .rs2_addr_in          (rs2_addr),
    .rs1_out              (rs1_data),
    .rs2_out              (rs2_data),
    .rf_ready_out         (rf_ready),
    .wr_drop_out          (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    rd_addr  = 5'd0;
    rd_data  = 32'h0;
    rs1_addr = 5'd3;
    rs2_addr = 5'd5;

    // Reset state.
    step();
    check_val("rst_ready", {31'd0, rf_ready}, 32'd0);
    check_val("rst_drop",  {31'd0, wr_drop},  32'd0);
    check_val("rst_rs1",   rs1_data, 32'h0);
    check_val("rst_rs2",   rs2_data, 32'h0);

    // First clear: ready exactly 32 cycles after release, dropped write at cycle 10.
    rst = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (c == 10) begin
        wr_en = 1'b1; rd_addr = 5'd3; rd_data = 32'h55555555;
      end
      step();
      wr_en = 1'b0; rd_data = 32'h0;
      check_val($sformatf("init_ready_c%0d", c), {31'd0, rf_ready}, {31'd0, (c == 32)});
      check_val($sformatf("init_rs1_c%0d", c), rs1_data, 32'h0);
      check_val($sformatf("init_rs2_c%0d", c), rs2_data, 32'h0);
      if (c == 10) check_val("drop_pulse", {31'd0, wr_drop}, 32'd1);
      if (c == 11) check_val("drop_end",   {31'd0, wr_drop}, 32'd0);
    end

    // Dropped write left x3 cleared.
    rs1_addr = 5'd3;
    step();
    check_val("x3_after_drop", rs1_data, 32'h0);

    // Plain write then read one cycle later; rd_in is X while idle.
    wr_en = 1'b1; rd_addr = 5'd5; rd_data = 32'h12345678; rs1_addr = 5'd1; rs2_addr = 5'd2;
    step();
    wr_en = 1'b0; rd_data = 'x; rs1_addr = 5'd5; rs2_addr = 5'd5;
    step();
    check_val("x5_rs1", rs1_data, 32'h12345678);
    check_val("x5_rs2", rs2_data, 32'h12345678);
    check_val("x5_drop", {31'd0, wr_drop}, 32'd0);

    // Same-edge write-first bypass on both ports.
    wr_en = 1'b1; rd_addr = 5'd7; rd_data = 32'hAABBCCDD; rs1_addr = 5'd7; rs2_addr = 5'd7;
    step();
    check_val("byp_rs1", rs1_data, 32'hAABBCCDD);
    check_val("byp_rs2", rs2_data, 32'hAABBCCDD);
    wr_en = 1'b0; rd_data = 32'h0;
    step();
    check_val("x7_stored", rs1_data, 32'hAABBCCDD);

    // Writes to x0 are discarded and x0 reads zero.
    wr_en = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; rs1_addr = 5'd5; rs2_addr = 5'd0;
    step();
    check_val("x0_same_edge", rs2_data, 32'h0);
    check_val("x0_rs1_other", rs1_data, 32'h12345678);
    wr_en = 1'b0; rs1_addr = 5'd0;
    step();
    check_val("x0_later_rs1", rs1_data, 32'h0);
    check_val("x0_later_rs2", rs2_data, 32'h0);

    // Fill x1..x31 with index * 0x01010101 and read every entry back.
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; rd_addr = 5'(i); rd_data = 32'(i) * 32'h01010101;
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      step();
      check_val($sformatf("fill_rs1_x%0d", i), rs1_data, 32'(i) * 32'h01010101);
      check_val($sformatf("fill_rs2_x%0d", 31 - i), rs2_data, 32'(31 - i) * 32'h01010101);
    end

    // Second clear interrupted by a reset pulse; the walk restarts from zero.
    rst = 1'b1;
    step();
    check_val("rst2_ready", {31'd0, rf_ready}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check_val("mid_init_ready", {31'd0, rf_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    while (rf_ready !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    check_val("restart_latency", 32'(cyc), 32'd32);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      step();
      check_val($sformatf("clr_rs1_x%0d", i), rs1_data, 32'h0);
      check_val($sformatf("clr_rs2_x%0d", 31 - i), rs2_data, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
